// File: rtl/cpu_ctrl.sv
// Instruction register, decoder and multi-cycle sequencer for the simple RISC datapath.
// Optional illegal-opcode trap state enabled by defining CPU_CTRL_ILLEGAL_TRAP_EN.
module cpu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        err
);
    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_CMP, S_WR_RD
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        , S_ERR
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    logic       is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign rm  = ir_q[2:0];

    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    assign is_add     = (opc == 3'b101) && (op == 2'b00);
    assign is_cmp     = (opc == 3'b101) && (op == 2'b01);
    assign is_and     = (opc == 3'b101) && (op == 2'b10);
    assign is_mvn     = (opc == 3'b101) && (op == 2'b11);

    assign ALUop  = op;
    assign shift  = ir_q[4:3];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                // load and s share an edge so DECODE already sees the new word
                if (load) ir_d = in;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                  state_d = S_WR_IMM;
                else if (is_mov_reg || is_mvn)   state_d = S_GET_B;
                else if (is_add || is_and || is_cmp) state_d = S_GET_A;
                else
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    state_d = S_ERR;
`else
                    state_d = S_WAIT;
`endif
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = is_cmp ? S_CMP : S_ALU;
            S_ALU:    state_d = S_WR_RD;
            S_WR_IMM, S_CMP, S_WR_RD: state_d = S_WAIT;
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        err      = 1'b0;
        case (state_q)
            S_WAIT:   w = 1'b1;
            S_WR_IMM: begin writenum = rn; write = 1'b1; vsel = 2'b10; end
            S_GET_A:  begin readnum = rn; loada = 1'b1; end
            S_GET_B:  begin readnum = rm; loadb = 1'b1; end
            S_ALU:    begin loadc = 1'b1; asel = is_mov_reg || is_mvn; end
            S_CMP:    loads = 1'b1;
            S_WR_RD:  begin writenum = rd; write = 1'b1; end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_ERR:    err = 1'b1;
`endif
            default:  ;
        endcase
    end
endmodule
